// File: rtl/pipe_mux_n_pkg.sv
// Shared constants and the reference N-way select function for pipe_mux_n.
package pipe_mux_n_pkg;

  localparam int unsigned MaxNumIn = 16;
  // Widest channel the shared select function can carry.
  localparam int unsigned MaxWidth = 128;
  localparam int unsigned MaxBits  = MaxNumIn * MaxWidth;

  // Returns channel `sel` of `data` (channels packed `width` bits apart), or 0 when
  // `sel` is not a valid channel index.
  function automatic logic [MaxWidth-1:0] pipe_mux_sel(input logic [MaxBits-1:0] data,
                                                       input int unsigned      sel,
                                                       input int unsigned      width,
                                                       input int unsigned      num_in);
    logic [MaxWidth-1:0] mask;
    if (sel >= num_in) begin
      return '0;
    end
    mask = {MaxWidth{1'b1}} >> (MaxWidth - width);
    return MaxWidth'(data >> (sel * width)) & mask;
  endfunction

endpackage

// File: rtl/pipe_mux_n_if.sv
// Upstream/downstream handshake bundle of the back-pressured N-way select stage.
interface pipe_mux_n_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned SEL_W  = $clog2(NUM_IN)
);
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;

  // Environment side: drives operands, flush and downstream ready.
  modport master (
    output in_data, sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_valid, sel_err
  );

  // Stage side.
  modport slave (
    input  in_data, sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_valid, sel_err
  );
endinterface

// File: rtl/pipe_mux_n_mux_n_comb.sv
// Purely combinational N-to-1 WIDTH-bit selector with an out-of-range flag.
module mux_n_comb import pipe_mux_n_pkg::*; #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]        sel_i,
  output logic [WIDTH-1:0]        data_o,
  output logic                    oor_o
);

  logic [MaxBits-1:0]  data_ext;
  logic [MaxWidth-1:0] sel_val;

  // Widen to the package's fixed-size view and pick the channel.
  always_comb begin
    data_ext = MaxBits'(data_i);
    sel_val  = pipe_mux_sel(data_ext, 32'(sel_i), WIDTH, NUM_IN);
    data_o   = sel_val[WIDTH-1:0];
  end

  // A power-of-two channel count leaves no unused select codes.
  if ((1 << SEL_W) == NUM_IN) begin : g_pow2
    assign oor_o = 1'b0;
  end else begin : g_oor
    assign oor_o = (32'(sel_i) >= NUM_IN);
  end

endmodule

// File: rtl/pipe_mux_n.sv
// N-way operand select with a registered output and a two-entry (main + skid) buffer.
module pipe_mux_n import pipe_mux_n_pkg::*; #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned SEL_W  = $clog2(NUM_IN)
) (
  input logic          clk_i,
  input logic          reset_i,
  pipe_mux_n_if.slave  bus
);

  logic [WIDTH-1:0] new_data;
  logic             new_oor;
  logic             accept;
  logic             drain;

  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic             sel_err_q, sel_err_d;

  mux_n_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_mux (
    .data_i (bus.in_data),
    .sel_i  (bus.sel),
    .data_o (new_data),
    .oor_o  (new_oor)
  );

  // in_ready comes straight from the skid flag, so out_ready never reaches it combinationally.
  assign accept = bus.in_valid && !skid_v_q;
  assign drain  = main_v_q && bus.out_ready;

  // Next-state of the main/skid pair and the sticky select-error flag.
  always_comb begin
    main_v_d    = main_v_q;
    main_data_d = main_data_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    // Flush does not mask this: an out-of-range accept is still recorded.
    sel_err_d   = sel_err_q | (accept & new_oor);

    if (bus.flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || drain) begin
      if (skid_v_q) begin
        // accept is necessarily low here, so the skid simply empties into main.
        main_v_d    = 1'b1;
        main_data_d = skid_data_q;
        skid_v_d    = 1'b0;
      end else if (accept) begin
        main_v_d    = 1'b1;
        main_data_d = new_data;
      end else if (drain) begin
        main_v_d = 1'b0;
      end
    end else if (accept) begin
      skid_v_d    = 1'b1;
      skid_data_d = new_data;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      main_v_q    <= 1'b0;
      main_data_q <= '0;
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      main_v_q    <= main_v_d;
      main_data_q <= main_data_d;
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign bus.in_ready  = !skid_v_q;
  assign bus.out_valid = main_v_q;
  assign bus.out_data  = main_data_q;
  assign bus.sel_err   = sel_err_q;

endmodule
